commit_trace_unit: RTL
======================

Name: commit_trace_unit

Overview:
- Synthesizable, parametrised commit-trace capture unit that sits beside the pipelined cpu and observes one retirement per cycle from the writeback/memory boundary.
- Classifies each retired instruction as REG, LOAD, STORE, OTHER or HALT and stamps it with a 0-based instruction number.
- Buffers the records in an internal FIFO that a debug port or bench drains through a valid/ready handshake.
- Maintains cycle and instruction counters, a halt-done state and a watchdog timeout.

Parameters:
- DATA_W, 16: width of pc, instruction, data and address fields.
- REG_W, 4: width of destination register index.
- DEPTH, 16: FIFO entries; power of two, >= 2.
- CNT_W, 32: width of the cycle, instruction and drop counters.
- WDOG_CYCLES, 100000: RUN cycles allowed before timeout.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- commit_valid  in  1  one instruction retires this cycle.
- commit_pc  in  DATA_W  pc of the retiring instruction.
- commit_inst  in  DATA_W  instruction word.
- reg_write  in  1  retiring instruction writes the register file.
- wr_reg  in  REG_W  destination register.
- wr_data  in  DATA_W  register write data.
- mem_read  in  1  retiring instruction is a load.
- mem_write  in  1  retiring instruction is a store.
- mem_addr  in  DATA_W  memory address.
- mem_data  in  DATA_W  store data.
- halt  in  1  retiring instruction is HLT.
- rd_valid  out  1  FIFO head record valid.
- rd_ready  in  1  consumer accepts the head record.
- rd_type  out  3  record type: 0 REG, 1 LOAD, 2 STORE, 3 OTHER, 4 HALT.
- rd_inum  out  CNT_W  instruction number.
- rd_pc  out  DATA_W  record pc.
- rd_reg  out  REG_W  destination register; 0 unless REG or LOAD.
- rd_value  out  DATA_W  wr_data for REG/LOAD, mem_data for STORE, else 0.
- rd_addr  out  DATA_W  mem_addr for LOAD/STORE, else 0.
- cycle_count  out  CNT_W  cycles spent in RUN.
- inst_count  out  CNT_W  instructions retired.
- drop_count  out  CNT_W  records lost to a full FIFO.
- overflow  out  1  sticky; set on the first drop.
- done  out  1  state is HALTED.
- timeout  out  1  state is TIMEOUT.

Behaviour:
- Reset: state RUN; FIFO empty; all counters 0; overflow, done, timeout and rd_valid all 0; rd_* fields 0.
- States and transitions:
  - RUN -> HALTED on a capture with halt=1.
  - RUN -> TIMEOUT when cycle_count == WDOG_CYCLES-1 and no halt capture occurs that cycle.
  - HALTED and TIMEOUT are terminal until rst.
- Capture happens when commit_valid=1 and state is RUN.
- Classification, highest priority first:
  - reg_write & mem_read -> LOAD
  - reg_write -> REG
  - halt -> HALT
  - mem_write -> STORE
  - otherwise OTHER
- Each capture takes rd_inum = inst_count before the update; inst_count then increments by 1. This applies to dropped records too.
- cycle_count increments every cycle while in RUN and freezes in HALTED/TIMEOUT. All counters wrap modulo 2^CNT_W.
- FIFO push and pop:
  - A record is pushed the cycle after capture is registered.
  - It becomes visible on rd_* with rd_valid=1 the next cycle, i.e. first-word latency 1 cycle.
  - Pop occurs when rd_valid & rd_ready.
  - rd_* stays stable while rd_valid=1 and rd_ready=0.
- Full FIFO:
  - A capture while full with no pop that cycle is dropped: drop_count+1, overflow set to 1.
  - A capture while full with a simultaneous pop is accepted; occupancy is unchanged.
- Empty FIFO: rd_valid=0, and rd_ready is ignored.
- Pointers wrap at DEPTH.
- A HALT record that is dropped still moves the state to HALTED.
- Records already buffered remain drainable in HALTED and TIMEOUT.
- commit_valid=0: no capture and no inst_count change; field inputs are don't-care.
- rst asserted mid-operation clears everything on the next edge, including buffered records.

Test Plan:
- Reset, then three commits: REG (r3=0x1234), store (addr 0x0040, data 0xBEEF), branch with no writes. With rd_ready=1 the bench sees types 0, 2, 3, inum 0, 1, 2, rd_value 0x1234/0xBEEF/0, and inst_count=3.
- Load with reg_write=mem_read=1, r5=0x00AA, addr 0x0010 -> rd_type=1, rd_reg=5, rd_value=0x00AA, rd_addr=0x0010.
- DEPTH=4, rd_ready=0, six commits -> four records held, drop_count=2, overflow=1, inst_count=6. Draining yields inum 0..3 in order.
- Full FIFO, then a commit and rd_ready=1 in the same cycle -> no drop; occupancy stays 4; the new record appears at the tail.
- HALT at inum 7, followed by further commit_valid pulses -> done=1 the next cycle; inst_count stays 8; cycle_count frozen; the HALT record is drainable.
- WDOG_CYCLES=20, no halt -> timeout=1 after cycle_count reaches 19; commits afterwards are ignored. rst=1 mid-run returns every output to 0 on the next edge.

Source files
------------

// File: rtl/commit_trace_unit.sv
// commit_trace_unit
//   Watches one retirement per cycle at the writeback/memory boundary. Each
//   retired instruction is classified (REG, LOAD, STORE, OTHER, HALT), stamped
//   with a 0-based instruction number and buffered in a FIFO. A consumer
//   drains the FIFO with a valid/ready handshake. Cycle, instruction and drop
//   counters, a halt-done state and a watchdog timeout are also kept.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   commit_*          retirement observation (valid, pc, inst)
//   reg_write..halt   side effects of the retiring instruction
//   rd_valid/rd_ready FIFO head handshake
//   rd_type..rd_addr  FIFO head record fields (0 while empty)
//   cycle_count       cycles spent in RUN
//   inst_count        instructions retired while in RUN
//   drop_count        records lost to a full FIFO
//   overflow          sticky flag, set on the first drop
//   done / timeout    state is HALTED / TIMEOUT
module commit_trace_unit #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned REG_W       = 4,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned WDOG_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              commit_valid,
    input  logic [DATA_W-1:0] commit_pc,
    input  logic [DATA_W-1:0] commit_inst,
    input  logic              reg_write,
    input  logic [REG_W-1:0]  wr_reg,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              halt,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [2:0]        rd_type,
    output logic [CNT_W-1:0]  rd_inum,
    output logic [DATA_W-1:0] rd_pc,
    output logic [REG_W-1:0]  rd_reg,
    output logic [DATA_W-1:0] rd_value,
    output logic [DATA_W-1:0] rd_addr,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  inst_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic              overflow,
    output logic              done,
    output logic              timeout
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);

    localparam logic [2:0] TYPE_REG   = 3'd0;
    localparam logic [2:0] TYPE_LOAD  = 3'd1;
    localparam logic [2:0] TYPE_STORE = 3'd2;
    localparam logic [2:0] TYPE_OTHER = 3'd3;
    localparam logic [2:0] TYPE_HALT  = 3'd4;

    typedef enum logic [1:0] {StRun, StHalted, StTimeout} state_e;

    typedef struct packed {
        logic [2:0]        typ;
        logic [CNT_W-1:0]  inum;
        logic [DATA_W-1:0] pc;
        logic [REG_W-1:0]  dst;
        logic [DATA_W-1:0] value;
        logic [DATA_W-1:0] addr;
    } rec_t;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cycle_q, inst_q, drop_q;
    logic              overflow_q;
    logic              cap_valid_q;
    rec_t              cap_rec, cap_rec_q;
    logic              capture;

    rec_t              mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q;
    logic              push, pop, full, accept, drop;
    rec_t              head;

    // The instruction word is observed but not part of the trace record.
    logic unused_inputs;
    assign unused_inputs = ^commit_inst;

    assign capture = commit_valid && (state_q == StRun);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun: begin
                if (capture && halt) begin
                    state_d = StHalted;
                end else if (cycle_q == WDOG_LAST) begin
                    state_d = StTimeout;
                end
            end
            default: state_d = state_q;
        endcase
    end

    // Record fields that do not apply to the type are forced to 0.
    always_comb begin
        cap_rec      = '0;
        cap_rec.inum = inst_q;
        cap_rec.pc   = commit_pc;
        if (reg_write && mem_read) begin
            cap_rec.typ   = TYPE_LOAD;
            cap_rec.dst   = wr_reg;
            cap_rec.value = wr_data;
            cap_rec.addr  = mem_addr;
        end else if (reg_write) begin
            cap_rec.typ   = TYPE_REG;
            cap_rec.dst   = wr_reg;
            cap_rec.value = wr_data;
        end else if (halt) begin
            cap_rec.typ   = TYPE_HALT;
        end else if (mem_write) begin
            cap_rec.typ   = TYPE_STORE;
            cap_rec.value = mem_data;
            cap_rec.addr  = mem_addr;
        end else begin
            cap_rec.typ   = TYPE_OTHER;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            cycle_q     <= '0;
            inst_q      <= '0;
            cap_valid_q <= 1'b0;
            cap_rec_q   <= '0;
        end else begin
            state_q     <= state_d;
            if (state_q == StRun) begin
                cycle_q <= cycle_q + 1'b1;
            end
            if (capture) begin
                inst_q    <= inst_q + 1'b1;
                cap_rec_q <= cap_rec;
            end
            cap_valid_q <= capture;
        end
    end

    // FIFO: the registered capture is pushed one cycle later. A full FIFO
    // still accepts the push when the head is popped on the same edge.
    assign push   = cap_valid_q;
    assign pop    = rd_valid && rd_ready;
    assign full   = (count_q == FULL_CNT);
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop) begin
                drop_q     <= drop_q + 1'b1;
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_q] <= cap_rec_q;
        end
    end

    assign head     = mem[rd_ptr_q];
    assign rd_valid = (count_q != '0);
    assign rd_type  = rd_valid ? head.typ   : '0;
    assign rd_inum  = rd_valid ? head.inum  : '0;
    assign rd_pc    = rd_valid ? head.pc    : '0;
    assign rd_reg   = rd_valid ? head.dst   : '0;
    assign rd_value = rd_valid ? head.value : '0;
    assign rd_addr  = rd_valid ? head.addr  : '0;

    assign cycle_count = cycle_q;
    assign inst_count  = inst_q;
    assign drop_count  = drop_q;
    assign overflow    = overflow_q;
    assign done        = (state_q == StHalted);
    assign timeout     = (state_q == StTimeout);

endmodule
